keynsham_dbus_master: RTL and testbench

KEYNSHAM_DBUS_MASTER -- requirements
Module: keynsham_dbus_master

---
 rtl/keynsham_dbus_master.sv | 178 +++++++++++++++++
 tb/tb_keynsham_dbus_master.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keynsham_dbus_master.sv
// Single-outstanding load/store master for the keynsham data bus: aligns, lane-replicates, extends.
// Optional bus-watchdog abort is compiled in with `define KEYNSHAM_BUS_TIMEOUT_EN.
module keynsham_dbus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        d_access,
    output logic [31:0] d_addr,
    output logic [3:0]  d_bytesel,
    output logic [31:0] d_wr_val,
    output logic        d_wr_en,
    input  logic [31:0] d_data,
    input  logic        d_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] d_addr_q, d_addr_d, d_wr_val_q, d_wr_val_d, rsp_rdata_q, rsp_rdata_d;
    logic [3:0]  d_bytesel_q, d_bytesel_d;
    logic        d_access_q, d_access_d, d_wr_en_q, d_wr_en_d, rsp_err_q, rsp_err_d;
    logic        wr_q, wr_d, signed_q, signed_d;
    logic [1:0]  off_q, off_d, size_q, size_d;
    logic        accept, misalign, ack_hit, timeout_hit;
    logic [31:0] load_ext;

    assign accept   = req_valid && req_ready;
    assign misalign = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0])
                   || (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    assign ack_hit  = (state_q == ACCESS) && d_ack;

`ifdef KEYNSHAM_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout_hit = (state_q == ACCESS) && !d_ack && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (accept)
            tmo_cnt_d = '0;
        else if (state_q == ACCESS && !d_ack)
            tmo_cnt_d = tmo_cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            d_addr_q    <= '0;
            d_bytesel_q <= '0;
            d_wr_val_q  <= '0;
            d_access_q  <= 1'b0;
            d_wr_en_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wr_q        <= 1'b0;
            signed_q    <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
        end else begin
            state_q     <= state_d;
            d_addr_q    <= d_addr_d;
            d_bytesel_q <= d_bytesel_d;
            d_wr_val_q  <= d_wr_val_d;
            d_access_q  <= d_access_d;
            d_wr_en_q   <= d_wr_en_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wr_q        <= wr_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            size_q      <= size_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = misalign ? RESP : ACCESS;
            ACCESS:  if (ack_hit || timeout_hit) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        rsp_valid = (state_q == RESP);
    end

    // Load alignment and extension use the request attributes captured at accept.
    always_comb begin
        load_ext = d_data;
        case (size_q)
            2'd0: load_ext = {{24{signed_q & d_data[{off_q, 3'b000} + 5'd7]}},
                              d_data[{off_q, 3'b000} +: 8]};
            2'd1: load_ext = {{16{signed_q & d_data[{off_q[1], 4'b0000} + 5'd15]}},
                              d_data[{off_q[1], 4'b0000} +: 16]};
            default: load_ext = d_data;
        endcase
    end

    always_comb begin
        d_addr_d    = d_addr_q;
        d_bytesel_d = d_bytesel_q;
        d_wr_val_d  = d_wr_val_q;
        d_access_d  = 1'b0;
        d_wr_en_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wr_d        = wr_q;
        signed_d    = signed_q;
        off_d       = off_q;
        size_d      = size_q;
        if (accept) begin
            wr_d        = req_wr;
            signed_d    = req_signed;
            off_d       = req_addr[1:0];
            size_d      = req_size;
            rsp_rdata_d = '0;
            rsp_err_d   = misalign;
            if (!misalign) begin
                d_addr_d   = {req_addr[31:2], 2'b00};
                d_access_d = 1'b1;
                d_wr_en_d  = req_wr;
                case (req_size)
                    2'd0: begin
                        d_bytesel_d = 4'b0001 << req_addr[1:0];
                        d_wr_val_d  = {4{req_wdata[7:0]}};
                    end
                    2'd1: begin
                        d_bytesel_d = req_addr[1] ? 4'b1100 : 4'b0011;
                        d_wr_val_d  = {2{req_wdata[15:0]}};
                    end
                    default: begin
                        d_bytesel_d = 4'b1111;
                        d_wr_val_d  = req_wdata;
                    end
                endcase
            end
        end else if (ack_hit) begin
            rsp_rdata_d = wr_q ? 32'd0 : load_ext;
            rsp_err_d   = 1'b0;
        end else if (timeout_hit) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
        end
    end

    assign d_addr    = d_addr_q;
    assign d_bytesel = d_bytesel_q;
    assign d_wr_val  = d_wr_val_q;
    assign d_access  = d_access_q;
    assign d_wr_en   = d_wr_en_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_keynsham_dbus_master.sv
// Bench for keynsham_dbus_master: directed vectors plus random transactions against a byte-lane model.
// Timeout abort is exercised only when KEYNSHAM_BUS_TIMEOUT_EN is defined.
module tb_keynsham_dbus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        d_access, d_wr_en, d_ack;
    logic [31:0] d_addr, d_wr_val, d_data;
    logic [3:0]  d_bytesel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    keynsham_dbus_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr(req_wr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .d_access(d_access), .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_val(d_wr_val),
        .d_wr_en(d_wr_en), .d_data(d_data), .d_ack(d_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: the access touches lanes off..off+n-1; store data repeats every n lanes.
    function automatic void model(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                                  input logic sgn, input logic [31:0] wdata, input logic [31:0] bus,
                                  output logic err, output logic [3:0] bs, output logic [31:0] wv,
                                  output logic [31:0] rd);
        int n, off;
        logic [63:0] val;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
        err = (size == 2'd3) || (off % n != 0);
        bs  = '0;
        wv  = '0;
        val = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + n) bs[i] = 1'b1;
            wv[8*i +: 8] = wdata[8*(i % n) +: 8];
        end
        if (!err) begin
            for (int i = n - 1; i >= 0; i--) val = val * 256 + 64'(bus[8*(off+i) +: 8]);
            if (sgn && n < 4 && val >= (64'd1 << (8*n - 1))) val = val - (64'd1 << (8*n));
        end
        rd = (err || wr) ? 32'd0 : val[31:0];
    endfunction

    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata, input logic [31:0] bus,
                           input int delay, input logic ack_in_resp);
        logic err;
        logic [3:0]  bs;
        logic [31:0] wv, rd;
        model(addr, wr, size, sgn, wdata, bus, err, bs, wv, rd);
        @(negedge clk);
        chk("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = addr; req_wr = wr; req_size = size;
        req_signed = sgn; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        if (err) begin
            chk("err_no_access", 32'(d_access), 32'd0);
        end else begin
            chk("access_pulse", 32'(d_access), 32'd1);
            chk("wr_en", 32'(d_wr_en), 32'(wr));
            chk("d_addr", d_addr, {addr[31:2], 2'b00});
            chk("bytesel", 32'(d_bytesel), 32'(bs));
            if (wr) chk("wr_val", d_wr_val, wv);
            chk("no_rsp_early", 32'(rsp_valid), 32'd0);
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                chk("access_single", 32'(d_access), 32'd0);
                chk("wr_en_single", 32'(d_wr_en), 32'd0);
                chk("addr_stable", d_addr, {addr[31:2], 2'b00});
                chk("bytesel_stable", 32'(d_bytesel), 32'(bs));
                chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
            end
            d_ack = 1'b1; d_data = bus;
            @(negedge clk);
            d_ack = 1'b0; d_data = $urandom;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(err));
        chk("rsp_rdata", rsp_rdata, rd);
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        d_ack = ack_in_resp;
        @(negedge clk);
        d_ack = 1'b0;
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
        chk("idle_no_access", 32'(d_access), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sz;
        logic [31:0] a;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_size = '0;
        req_signed = 1'b0; req_wdata = '0; d_ack = 1'b0; d_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_access", 32'(d_access), 32'd0);
        chk("rst_wr_en", 32'(d_wr_en), 32'd0);
        chk("rst_addr", d_addr, 32'd0);
        chk("rst_bytesel", 32'(d_bytesel), 32'd0);
        chk("rst_wr_val", d_wr_val, 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_release", 32'(req_ready), 32'd1);

        run_txn(32'h104, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1, 1'b0);
        run_txn(32'h103, 1'b0, 2'd0, 1'b1, 32'h0, 32'h80112233, 1, 1'b0);
        chk("sx_byte_const", rsp_rdata, 32'hFFFFFF80);
        run_txn(32'h103, 1'b0, 2'd0, 1'b0, 32'h0, 32'h80112233, 1, 1'b0);
        chk("zx_byte_const", rsp_rdata, 32'h00000080);
        run_txn(32'h22, 1'b1, 2'd1, 1'b0, 32'h0000ABCD, 32'h0, 1, 1'b0);
        chk("half_wr_val_const", d_wr_val, 32'hABCDABCD);
        run_txn(32'h102, 1'b0, 2'd2, 1'b0, 32'h0, 32'h12345678, 0, 1'b0);
        run_txn(32'h41, 1'b0, 2'd1, 1'b1, 32'h0, 32'h12345678, 0, 1'b1);
        run_txn(32'h40, 1'b1, 2'd3, 1'b0, 32'h55, 32'h0, 0, 1'b0);
        run_txn(32'h42, 1'b0, 2'd1, 1'b1, 32'h0, 32'h9ABC1234, 0, 1'b1);
        run_txn(32'h48, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 3, 1'b0);

        // Ack while idle must not produce a response.
        @(negedge clk);
        d_ack = 1'b1; d_data = 32'hFFFFFFFF;
        @(negedge clk);
        d_ack = 1'b0;
        chk("idle_ack_ignored", 32'(rsp_valid), 32'd0);
        chk("idle_ack_ready", 32'(req_ready), 32'd1);

        // Reset during ACCESS, ack arriving just after release.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h80; req_wr = 1'b0; req_size = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_access", 32'(d_access), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_access", 32'(d_access), 32'd0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        rst = 1'b0; d_ack = 1'b1; d_data = 32'h11111111;
        #1 chk("mid_rst_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        d_ack = 1'b0;
        chk("late_ack_no_rsp", 32'(rsp_valid), 32'd0);
        run_txn(32'h84, 1'b0, 2'd2, 1'b0, 32'h0, 32'h76543210, 1, 1'b0);

`ifdef KEYNSHAM_BUS_TIMEOUT_EN
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h200; req_wr = 1'b0; req_size = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        chk("tmo_access", 32'(d_access), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("tmo_waiting", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
        chk("tmo_rdata", rsp_rdata, 32'd0);
        d_ack = 1'b1; d_data = 32'hFFFFFFFF;
        @(negedge clk);
        d_ack = 1'b0;
        chk("tmo_late_ack", 32'(rsp_valid), 32'd0);
        chk("tmo_ready", 32'(req_ready), 32'd1);
`endif

        for (int k = 0; k < 80; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            run_txn(a, 1'($urandom), sz, 1'($urandom), $urandom, $urandom,
                    $urandom_range(0, 3), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
